// File: rtl/credential_entry_if.sv
// Button/consumer bundle for the credential keypad: raw buttons and lockout in, entered digits out.
// No flow control; the consumer uses resetCount to clear a completed or stale entry.
interface credential_entry_if;
    logic       btn1;
    logic       btn2;
    logic       btn3;
    logic       btn4;
    logic       btn5;
    logic       locker;
    logic       resetCount;
    logic [3:0] inputCount;
    logic [3:0] userNameInput0;
    logic [3:0] userNameInput1;
    logic [3:0] userNameInput2;
    logic [3:0] userNameInput3;
    logic [3:0] passwordInput0;
    logic [3:0] passwordInput1;
    logic [3:0] passwordInput2;
    logic [3:0] passwordInput3;
    logic       entryPulse;

    modport master (
        output btn1, btn2, btn3, btn4, btn5, locker, resetCount,
        input  inputCount, userNameInput0, userNameInput1, userNameInput2, userNameInput3,
        input  passwordInput0, passwordInput1, passwordInput2, passwordInput3, entryPulse
    );

    modport slave (
        input  btn1, btn2, btn3, btn4, btn5, locker, resetCount,
        output inputCount, userNameInput0, userNameInput1, userNameInput2, userNameInput3,
        output passwordInput0, passwordInput1, passwordInput2, passwordInput3, entryPulse
    );
endinterface

// File: rtl/credential_entry.sv
// 8-digit username/password entry from debounced-by-sync buttons; raw press to outputs in 3 clocks.
// No backpressure: presses are dropped while locked, in DONE, or when several land in one cycle.
module credential_entry #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int DONE_HOLD      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    credential_entry_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(DONE_HOLD + 1);

    typedef enum logic [1:0] {IDLE, USER, PASS, DONE} state_t;

    logic [4:0] raw, sync1, sync2, sync3, armed, press;
    logic       sync_vld;

    assign raw = {bus.btn5, bus.btn4, bus.btn3, bus.btn2, bus.btn1};

    // A button must be seen low after reset before its rising edge counts,
    // so a button held through reset release does not register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            sync3    <= '0;
            armed    <= '0;
            sync_vld <= 1'b0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            sync3    <= sync2;
            sync_vld <= 1'b1;
            armed    <= armed | ({5{sync_vld}} & ~sync1);
        end
    end

    assign press = sync2 & ~sync3 & armed;

    state_t        state_q, state_d;
    logic [3:0]    count_q, count_d;
    logic [3:0]    dig_q [8];
    logic [3:0]    dig_d [8];
    logic          pulse_q, pulse_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          single, accept, clear;
    logic [1:0]    val;
    logic [2:0]    last_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            pulse_q <= 1'b0;
            timer_q <= '0;
            hold_q  <= '0;
            for (int i = 0; i < 8; i++) dig_q[i] <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
            timer_q <= timer_d;
            hold_q  <= hold_d;
            for (int i = 0; i < 8; i++) dig_q[i] <= dig_d[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dig_d     = dig_q;
        pulse_d   = 1'b0;
        timer_d   = timer_q;
        hold_d    = hold_q;
        clear     = 1'b0;
        single    = ($countones(press) == 1);
        accept    = single && !bus.locker && (state_q != DONE);
        val       = press[1] ? 2'd1 : press[2] ? 2'd2 : press[3] ? 2'd3 : 2'd0;
        last_slot = count_q[2:0] - 3'd1;

        if (bus.resetCount) begin
            clear = 1'b1;
        end else if (state_q == DONE) begin
            if (int'(hold_q) >= DONE_HOLD - 1) clear = 1'b1;
            else                              hold_d = hold_q + HW'(1);
        end else if (accept && !press[4]) begin
            dig_d[count_q[2:0]] = {2'b00, val};
            count_d = count_q + 4'd1;
            pulse_d = 1'b1;
            timer_d = '0;
        end else if (accept && (count_q != 4'd0)) begin
            dig_d[last_slot] = 4'd0;
            count_d = count_q - 4'd1;
            pulse_d = 1'b1;
            timer_d = '0;
        end else if ((state_q == USER) || (state_q == PASS)) begin
            // Saturating: the clear fires one step before the counter could pass the limit.
            if (int'(timer_q) >= TIMEOUT_CYCLES - 1) clear = 1'b1;
            else                                     timer_d = timer_q + TW'(1);
        end

        if (clear) begin
            count_d = '0;
            pulse_d = 1'b0;
            timer_d = '0;
            hold_d  = '0;
            for (int i = 0; i < 8; i++) dig_d[i] = '0;
        end

        if (count_d == 4'd0)     state_d = IDLE;
        else if (count_d < 4'd4) state_d = USER;
        else if (count_d < 4'd8) state_d = PASS;
        else                     state_d = DONE;

        if (state_d != DONE) hold_d = '0;
    end

    assign bus.inputCount     = count_q;
    assign bus.userNameInput0 = dig_q[0];
    assign bus.userNameInput1 = dig_q[1];
    assign bus.userNameInput2 = dig_q[2];
    assign bus.userNameInput3 = dig_q[3];
    assign bus.passwordInput0 = dig_q[4];
    assign bus.passwordInput1 = dig_q[5];
    assign bus.passwordInput2 = dig_q[6];
    assign bus.passwordInput3 = dig_q[7];
    assign bus.entryPulse     = pulse_q;
endmodule

// File: doc/credential_entry.md
CREDENTIAL_ENTRY -- requirements
Module: credential_entry

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 5000, idle clocks allowed between presses before a partial entry is discarded.
REQ-002 Parameter: DONE_HOLD, default 2, clocks that inputCount stays at 8 before it auto-clears.
REQ-003 clk  input  1  system clock; every register updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn1..btn4  input  1 each  raw digit buttons for values 0, 1, 2, 3, asynchronous to clk.
REQ-006 btn5  input  1  raw backspace button, asynchronous to clk.
REQ-007 locker  input  1  lockout active; while high, no press is accepted.
REQ-008 resetCount  input  1  clear request from the consumer; takes effect synchronously.
REQ-009 inputCount  output  4  number of digits entered, 0..8.
REQ-010 userNameInput0..3  output  4 each  username digits in entry order.
REQ-011 passwordInput0..3  output  4 each  password digits in entry order.
REQ-012 entryPulse  output  1  one-clock strobe for each accepted digit or backspace.

Function
REQ-013 Each button passes through a 2-FF synchronizer; a press is the 0->1 edge of the synchronized level, giving at most one event per press.
REQ-014 The FSM states are IDLE (count 0), USER (count 1..3), PASS (count 4..7) and DONE (count 8).
REQ-015 A press is accepted only when locker=0, resetCount=0, the state is not DONE, and exactly one of btn1..btn5 edges occurs in that cycle.
REQ-016 Two or more edges in the same cycle are discarded with no change and no entryPulse.
REQ-017 An accepted digit is written to slot inputCount, and inputCount increments in the same clock.
REQ-018 Slots 0..3 map to userNameInput0..3; slots 4..7 map to passwordInput0..3.
REQ-019 The digit value is zero-extended to 4 bits.
REQ-020 Accepted backspace with count>0: decrement inputCount and clear the vacated slot to 0.
REQ-021 Backspace with count=0 is ignored, with no entryPulse.
REQ-022 entryPulse is asserted in the clock after the accepted edge, coincident with the updated outputs.
REQ-023 Digit latency from raw button rise to updated outputs is 3 clocks: 2 for synchronization, 1 for the update.
REQ-024 Transitions: IDLE->USER on the first digit; USER->PASS at count 4; PASS->DONE at count 8.
REQ-025 Backspace moves the FSM back across these boundaries, for example 4->3 returns to USER.
REQ-026 In DONE, inputCount holds 8 and all digits stay stable for DONE_HOLD clocks; the FSM then clears to IDLE.
REQ-027 In DONE, all presses are ignored.
REQ-028 Inactivity timer: it reloads on every accepted press and runs only in USER or PASS.
REQ-029 When the timer reaches TIMEOUT_CYCLES, clear to IDLE: count 0, all digits 0.
REQ-030 Clear means inputCount=0, all eight digit outputs 0, timer reset and FSM to IDLE, completed in one clock.
REQ-031 resetCount=1 performs a clear in the next clock from any state.
REQ-032 resetCount has priority over a simultaneous press, timeout, or DONE expiry.
REQ-033 locker=1 blocks new presses but does not clear stored digits; the timeout keeps running.
REQ-034 The timer width is clog2(TIMEOUT_CYCLES+1) and it saturates; there is no wrap-around.
REQ-035 The DONE hold counter uses the same saturating rule.
REQ-036 Outputs are registered, with no combinational path from inputs to outputs.

Reset
REQ-037 rst_n=0 immediately forces inputCount=0, all digit outputs=0, entryPulse=0, FSM=IDLE, both counters=0, and all synchronizer flops=0.
REQ-038 Reset asserted mid-entry discards the partial credential.
REQ-039 After rst_n rises, a button already high produces no event until it falls and rises again.

Verification
REQ-040 Press btn1,btn1,btn2,btn2,btn2,btn1,btn2,btn2 -> user=0,0,1,1 and pass=1,0,1,1; inputCount steps 1..8, 8 entryPulses; inputCount=8 for 2 clocks, then 0.
REQ-041 Enter 5 digits, btn5 twice, then btn4 -> inputCount 5,4,3,4 and slot 3 (userNameInput3)=3; slot 4 reads 0 after the backspaces.
REQ-042 Press btn1 and btn3 in the same synchronized cycle -> no change and no entryPulse; a later single btn3 -> count 1, userNameInput0=2.
REQ-043 locker=1, 3 presses -> inputCount unchanged; then locker=0 with TIMEOUT_CYCLES=20 and 2 digits entered, 20 idle clocks -> count 0 and all digits 0.
REQ-044 resetCount=1 in the same cycle as an accepted btn2 at count 6 -> next clock count=0, all digits 0, no entryPulse.
REQ-045 rst_n=0 pulse at count 7 -> outputs 0 immediately, asynchronously; with btn1 held through reset release -> no digit accepted until btn1 is re-pressed.
